// File: rtl/flit_sink_pkg.sv
// Shared flit-type encodings, FSM states and flit width derivation for the
// flit sink and the mux benches.
package flit_sink_pkg;

    function automatic int unsigned flit_width(input int unsigned type_w,
                                               input int unsigned payload_w);
        return type_w + payload_w;
    endfunction

    localparam int unsigned TYPE_W    = 2;
    localparam int unsigned PAYLOAD_W = 64;
    localparam int unsigned FLIT_W    = flit_width(TYPE_W, PAYLOAD_W);

    typedef enum logic [1:0] {
        TypeNone = 2'b00,
        TypeHead = 2'b01,
        TypeTail = 2'b10,
        TypeData = 2'b11
    } flit_type_e;

    typedef enum logic {
        StIdle = 1'b0,
        StBody = 1'b1
    } state_e;

endpackage

// File: rtl/popcount.sv
// Combinational population count of a Width-bit vector.
module popcount #(
    parameter int unsigned  Width = 66,
    localparam int unsigned CntW  = $clog2(Width + 1)
) (
    input  logic [Width-1:0] data_i,
    output logic [CntW-1:0]  count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < Width; i++) begin
            count_o = count_o + CntW'(data_i[i]);
        end
    end

endmodule

// File: rtl/flit_sink.sv
// Always-ready flit receiver: checks HEAD/DATA/TAIL framing, reports packet
// length and sticky protocol errors, and accumulates bus toggle activity.
module flit_sink #(
    parameter int unsigned  TYPE_W    = 2,
    parameter int unsigned  PAYLOAD_W = 64,
    parameter int unsigned  VCH_W     = 1,
    parameter int unsigned  LEN_W     = 8,
    parameter int unsigned  CNT_W     = 32,
    localparam int unsigned FLIT_W    = flit_sink_pkg::flit_width(TYPE_W, PAYLOAD_W)
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [FLIT_W-1:0] idata,
    input  logic              ivalid,
    input  logic [VCH_W-1:0]  ivch,
    input  logic              en,
    input  logic              clear,
    output logic              pkt_done,
    output logic [LEN_W-1:0]  pkt_len,
    output logic [VCH_W-1:0]  pkt_vch,
    output logic [CNT_W-1:0]  flit_cnt,
    output logic [CNT_W-1:0]  toggle_cnt,
    output logic              err_orphan,
    output logic              err_trunc,
    output logic              err_vch,
    output logic              err_type
);
    import flit_sink_pkg::*;

    localparam int unsigned PC_W = $clog2(FLIT_W + 1);

    logic [TYPE_W-1:0] ftype;
    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, len_inc;
    logic [VCH_W-1:0]  vch_q, vch_d;
    logic              done_q, done_d;
    logic [LEN_W-1:0]  pkt_len_q, pkt_len_d;
    logic [VCH_W-1:0]  pkt_vch_q, pkt_vch_d;
    logic [FLIT_W-1:0] prev_q;
    logic [PC_W-1:0]   toggles;
    logic [CNT_W-1:0]  flit_q, flit_d, tog_q, tog_d;
    logic [CNT_W:0]    tog_sum;
    logic              orphan_ev, trunc_ev, vch_ev, type_ev;
    // {orphan, trunc, vch, type}
    logic [3:0]        err_q, err_d;

    assign ftype   = idata[FLIT_W-1 -: TYPE_W];
    assign len_inc = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);

    popcount #(
        .Width(FLIT_W)
    ) u_popcount (
        .data_i (idata ^ prev_q),
        .count_o(toggles)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        vch_d     = vch_q;
        done_d    = 1'b0;
        pkt_len_d = pkt_len_q;
        pkt_vch_d = pkt_vch_q;
        orphan_ev = 1'b0;
        trunc_ev  = 1'b0;
        type_ev   = 1'b0;
        vch_ev    = ivalid && (state_q == StBody) && (ivch != vch_q);
        if (ivalid) begin
            case (ftype)
                TYPE_W'(TypeHead): begin
                    trunc_ev = (state_q == StBody);
                    state_d  = StBody;
                    len_d    = LEN_W'(1);
                    vch_d    = ivch;
                end
                TYPE_W'(TypeData): begin
                    if (state_q == StBody) len_d = len_inc;
                    else                   orphan_ev = 1'b1;
                end
                TYPE_W'(TypeTail): begin
                    if (state_q == StBody) begin
                        state_d   = StIdle;
                        done_d    = 1'b1;
                        pkt_len_d = len_inc;
                        pkt_vch_d = vch_q;
                    end else begin
                        orphan_ev = 1'b1;
                    end
                end
                default: type_ev = 1'b1;
            endcase
        end
    end

    // One extra carry bit detects overflow of the toggle accumulator.
    assign tog_sum = {1'b0, tog_q} + (CNT_W + 1)'(toggles);

    always_comb begin
        flit_d = flit_q;
        tog_d  = tog_q;
        err_d  = err_q | {orphan_ev, trunc_ev, vch_ev, type_ev};
        if (clear) begin
            flit_d = '0;
            tog_d  = '0;
            err_d  = '0;
        end else if (en) begin
            if (ivalid && (flit_q != {CNT_W{1'b1}})) flit_d = flit_q + CNT_W'(1);
            tog_d = tog_sum[CNT_W] ? {CNT_W{1'b1}} : tog_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q   <= StIdle;
            len_q     <= '0;
            vch_q     <= '0;
            done_q    <= 1'b0;
            pkt_len_q <= '0;
            pkt_vch_q <= '0;
            prev_q    <= '0;
            flit_q    <= '0;
            tog_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            vch_q     <= vch_d;
            done_q    <= done_d;
            pkt_len_q <= pkt_len_d;
            pkt_vch_q <= pkt_vch_d;
            prev_q    <= idata;
            flit_q    <= flit_d;
            tog_q     <= tog_d;
            err_q     <= err_d;
        end
    end

    assign pkt_done   = done_q;
    assign pkt_len    = pkt_len_q;
    assign pkt_vch    = pkt_vch_q;
    assign flit_cnt   = flit_q;
    assign toggle_cnt = tog_q;
    assign err_orphan = err_q[3];
    assign err_trunc  = err_q[2];
    assign err_vch    = err_q[1];
    assign err_type   = err_q[0];

endmodule

// File: tb/tb_flit_sink.sv
// Scoreboard bench for flit_sink: a packet-level reference model predicts every
// output cycle, and a negedge monitor compares the DUT against those predictions.
module tb_flit_sink;

    localparam int unsigned FLIT_W  = 66;
    localparam int unsigned VCH_W   = 1;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned CNT_W   = 16;
    localparam longint      CNT_MAX = 65535;
    localparam longint      LEN_MAX = 255;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_DATA = 2'b11;

    logic              clk    = 1'b0;
    logic              rst_   = 1'b0;
    logic [FLIT_W-1:0] idata  = '0;
    logic              ivalid = 1'b0;
    logic [VCH_W-1:0]  ivch   = '0;
    logic              en     = 1'b0;
    logic              clear  = 1'b0;
    logic              pkt_done;
    logic [LEN_W-1:0]  pkt_len;
    logic [VCH_W-1:0]  pkt_vch;
    logic [CNT_W-1:0]  flit_cnt;
    logic [CNT_W-1:0]  toggle_cnt;
    logic              err_orphan, err_trunc, err_vch, err_type;

    always #5 clk = ~clk;

    flit_sink #(
        .TYPE_W   (2),
        .PAYLOAD_W(64),
        .VCH_W    (VCH_W),
        .LEN_W    (LEN_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .idata     (idata),
        .ivalid    (ivalid),
        .ivch      (ivch),
        .en        (en),
        .clear     (clear),
        .pkt_done  (pkt_done),
        .pkt_len   (pkt_len),
        .pkt_vch   (pkt_vch),
        .flit_cnt  (flit_cnt),
        .toggle_cnt(toggle_cnt),
        .err_orphan(err_orphan),
        .err_trunc (err_trunc),
        .err_vch   (err_vch),
        .err_type  (err_type)
    );

    typedef struct {
        bit     done;
        longint len;
        longint vch;
        longint flits;
        longint toggles;
        bit     e_orphan;
        bit     e_trunc;
        bit     e_vch;
        bit     e_type;
    } out_t;

    int     checks   = 0;
    int     failures = 0;
    int     pulses   = 0;
    out_t   exp_q[$];
    out_t   m_out    = '{default: 0};
    out_t   mon_e;
    bit     m_in_pkt = 1'b0;
    longint m_len    = 0;
    logic [VCH_W-1:0]  m_vch  = '0;
    logic [FLIT_W-1:0] m_prev = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint min2(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    // Reference model: packet-level view of the link, one step per sampled cycle.
    task automatic model_step();
        logic [1:0] t;
        bit eo, et, ev, ey;
        longint tog;
        t  = idata[FLIT_W-1 -: 2];
        eo = 0; et = 0; ev = 0; ey = 0;
        m_out.done = 0;
        if (ivalid) begin
            ev = m_in_pkt && (ivch != m_vch);
            if (t == T_NONE) begin
                ey = 1;
            end else if (t == T_HEAD) begin
                et       = m_in_pkt;
                m_in_pkt = 1;
                m_len    = 1;
                m_vch    = ivch;
            end else if (!m_in_pkt) begin
                eo = 1;
            end else if (t == T_DATA) begin
                m_len = min2(m_len + 1, LEN_MAX);
            end else begin
                m_out.done = 1;
                m_out.len  = min2(m_len + 1, LEN_MAX);
                m_out.vch  = m_vch;
                m_in_pkt   = 0;
            end
        end
        tog    = $countones(idata ^ m_prev);
        m_prev = idata;
        if (clear) begin
            m_out.flits    = 0;
            m_out.toggles  = 0;
            m_out.e_orphan = 0;
            m_out.e_trunc  = 0;
            m_out.e_vch    = 0;
            m_out.e_type   = 0;
        end else begin
            if (en) begin
                if (ivalid) m_out.flits = min2(m_out.flits + 1, CNT_MAX);
                m_out.toggles = min2(m_out.toggles + tog, CNT_MAX);
            end
            m_out.e_orphan |= eo;
            m_out.e_trunc  |= et;
            m_out.e_vch    |= ev;
            m_out.e_type   |= ey;
        end
        exp_q.push_back(m_out);
    endtask

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            m_out    = '{default: 0};
            m_in_pkt = 0;
            m_len    = 0;
            m_vch    = '0;
            m_prev   = '0;
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (rst_ && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("pkt_done",   pkt_done,   mon_e.done);
            chk("pkt_len",    pkt_len,    mon_e.len);
            chk("pkt_vch",    pkt_vch,    mon_e.vch);
            chk("flit_cnt",   flit_cnt,   mon_e.flits);
            chk("toggle_cnt", toggle_cnt, mon_e.toggles);
            chk("err_orphan", err_orphan, mon_e.e_orphan);
            chk("err_trunc",  err_trunc,  mon_e.e_trunc);
            chk("err_vch",    err_vch,    mon_e.e_vch);
            chk("err_type",   err_type,   mon_e.e_type);
            if (pkt_done) pulses++;
        end
    end

    task automatic flit(input bit v, input logic [1:0] t, input logic [VCH_W-1:0] vc);
        @(negedge clk);
        ivalid = v;
        ivch   = vc;
        idata  = {t, $urandom(), $urandom()};
    endtask

    task automatic idle(input int n);
        repeat (n) flit(1'b0, T_NONE, ivch);
    endtask

    task automatic packet(input logic [VCH_W-1:0] vc, input int ndata);
        flit(1'b1, T_HEAD, vc);
        repeat (ndata) flit(1'b1, T_DATA, vc);
        flit(1'b1, T_TAIL, vc);
    endtask

    task automatic do_clear();
        @(negedge clk);
        ivalid = 1'b0;
        clear  = 1'b1;
        @(negedge clk);
        clear  = 1'b0;
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_done"},   pkt_done,   0);
        chk({tag, "_len"},    pkt_len,    0);
        chk({tag, "_vch"},    pkt_vch,    0);
        chk({tag, "_flits"},  flit_cnt,   0);
        chk({tag, "_toggle"}, toggle_cnt, 0);
        chk({tag, "_errs"},   {err_orphan, err_trunc, err_vch, err_type}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    int p0;

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_ = 1'b1;

        // Toggle accounting: 10 alternations of a 13-ones pattern, then 5 with en low.
        @(negedge clk);
        en = 1'b0; ivalid = 1'b0; idata = '0; clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            clear = 1'b0;
            en    = 1'b1;
            idata = (i % 2 == 0) ? 66'h1FFF0 : 66'h0;
        end
        sample();
        chk("toggle_10", toggle_cnt, 130);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en    = 1'b0;
            idata = (i % 2 == 0) ? 66'h1FFF0 : 66'h0;
        end
        sample();
        chk("toggle_hold", toggle_cnt, 130);

        // Single contiguous packet.
        en = 1'b1;
        do_clear();
        p0 = pulses;
        packet(1'b1, 20);
        sample();
        chk("single_done", pkt_done, 1);
        chk("single_len", pkt_len, 22);
        chk("single_vch", pkt_vch, 1);
        chk("single_flits", flit_cnt, 22);
        chk("single_errs", {err_orphan, err_trunc, err_vch, err_type}, 0);
        idle(2);
        chk("single_pulses", pulses - p0, 1);

        // Framing errors.
        do_clear();
        flit(1'b1, T_DATA, 1'b0);
        sample();
        chk("orphan_flag", err_orphan, 1);
        p0 = pulses;
        flit(1'b1, T_HEAD, 1'b0);
        flit(1'b1, T_DATA, 1'b0);
        flit(1'b1, T_HEAD, 1'b0);
        flit(1'b1, T_TAIL, 1'b0);
        sample();
        chk("trunc_flag", err_trunc, 1);
        chk("trunc_len", pkt_len, 2);
        idle(2);
        chk("trunc_pulses", pulses - p0, 1);

        // VC change and NONE flit inside a packet.
        do_clear();
        p0 = pulses;
        flit(1'b1, T_HEAD, 1'b0);
        flit(1'b1, T_DATA, 1'b1);
        flit(1'b1, T_NONE, 1'b0);
        flit(1'b1, T_TAIL, 1'b0);
        sample();
        chk("vch_flag", err_vch, 1);
        chk("type_flag", err_type, 1);
        chk("vch_len", pkt_len, 3);
        chk("vch_other_errs", {err_orphan, err_trunc}, 0);
        idle(2);
        chk("vch_pulses", pulses - p0, 1);

        // Asynchronous reset in the middle of a packet.
        p0 = pulses;
        flit(1'b1, T_HEAD, 1'b1);
        repeat (3) flit(1'b1, T_DATA, 1'b1);
        @(negedge clk);
        #2;
        ivalid = 1'b0;
        rst_   = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_ = 1'b1;
        flit(1'b1, T_TAIL, 1'b1);
        sample();
        chk("midreset_orphan", err_orphan, 1);
        chk("midreset_nodone", pkt_done, 0);
        idle(2);
        chk("midreset_pulses", pulses - p0, 0);

        // Ten packets separated by idle gaps.
        do_clear();
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            packet(VCH_W'(i % 2), 20);
            idle(7);
        end
        chk("gaps_pulses", pulses - p0, 10);
        chk("gaps_flits", flit_cnt, 220);

        // Toggle accumulator saturation, then clear against a colliding flit.
        for (int i = 0; i < 1020; i++) begin
            @(negedge clk);
            ivalid = 1'b0;
            idata  = (i % 2 == 0) ? {FLIT_W{1'b1}} : '0;
        end
        sample();
        chk("toggle_sat", toggle_cnt, CNT_MAX);
        @(negedge clk);
        clear  = 1'b1;
        ivalid = 1'b1;
        idata  = {T_DATA, $urandom(), $urandom()};
        sample();
        chk("clear_flits", flit_cnt, 0);
        chk("clear_toggle", toggle_cnt, 0);
        chk("clear_orphan", err_orphan, 0);
        @(negedge clk);
        clear  = 1'b0;
        ivalid = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [1:0] t;
            @(negedge clk);
            r      = $urandom_range(0, 99);
            t      = (r < 20) ? T_HEAD : (r < 70) ? T_DATA : (r < 95) ? T_TAIL : T_NONE;
            ivalid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) == 0) ivch = ~ivch;
            en     = ($urandom_range(0, 9) != 0);
            clear  = ($urandom_range(0, 49) == 0);
            idata  = {t, $urandom(), $urandom()};
        end
        @(negedge clk);
        clear  = 1'b0;
        ivalid = 1'b0;
        idle(3);
        sample();
        chk("scoreboard_depth", exp_q.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
